// File: rtl/led_sequencer.sv
// LED pattern engine: prescaled stepping through up/down/rotate/bounce patterns,
// with pause, manual single-step and seeded mode switching.
module led_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             step_now,
  output logic [WIDTH-1:0] leds,
  output logic             tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_ROT    = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_t;

  mode_t            mode_q, mode_d, mode_in;
  dir_t             dir, dir_d, stepped_dir;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] leds_d, stepped, seed;
  logic             tick_d, adv;

  assign mode_in = mode_t'(mode);

  always_comb begin
    stepped     = leds;
    stepped_dir = dir;
    case (mode_q)
      MODE_UP:   stepped = leds + WIDTH'(1);
      MODE_DOWN: stepped = leds - WIDTH'(1);
      MODE_ROT:  stepped = {leds[WIDTH-2:0], leds[WIDTH-1]};
      MODE_BOUNCE: begin
        // Reversal happens on the step that leaves an end, so ends are shown once.
        if (dir == LEFT) begin
          if (leds[WIDTH-1]) begin
            stepped_dir = RIGHT;
            stepped     = leds >> 1;
          end else begin
            stepped     = leds << 1;
          end
        end else begin
          if (leds[0]) begin
            stepped_dir = LEFT;
            stepped     = leds << 1;
          end else begin
            stepped     = leds >> 1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (mode_in)
      MODE_UP:   seed = '0;
      MODE_DOWN: seed = '1;
      default:   seed = WIDTH'(1);
    endcase
  end

  assign adv = (en && (cnt == CNT_MAX)) || (!en && step_now);

  always_comb begin
    mode_d = mode_q;
    leds_d = leds;
    dir_d  = dir;
    cnt_d  = cnt;
    tick_d = 1'b0;
    if (mode_in != mode_q) begin
      mode_d = mode_in;
      leds_d = seed;
      dir_d  = LEFT;
      cnt_d  = '0;
    end else if (adv) begin
      leds_d = stepped;
      dir_d  = stepped_dir;
      tick_d = 1'b1;
      // A manual step while paused leaves the frozen count untouched.
      if (en) cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_UP;
      leds   <= '0;
      dir    <= LEFT;
      cnt    <= '0;
      tick   <= 1'b0;
    end else begin
      mode_q <= mode_d;
      leds   <= leds_d;
      dir    <= dir_d;
      cnt    <= cnt_d;
      tick   <= tick_d;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer at WIDTH=4, DIV=4: vector table plus
// hand-written sequences for mode switching, wrap, bounce and async reset.
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       step_now = 1'b0;
  logic [3:0] leds;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;

  led_sequencer #(.WIDTH(4), .DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .step_now(step_now), .leds(leds), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       step;
    logic [3:0] leds;
    logic       tick;
  } vec_t;

  vec_t tbl [22];
  logic [3:0] bseq [7];
  logic [3:0] exp_l;

  task automatic check(input string name, input logic [3:0] el, input logic et);
    n_checks++;
    if (leds !== el) begin
      n_fail++;
      $display("FAIL %s: leds=%b expected %b at %0t", name, leds, el, $time);
    end
    n_checks++;
    if (tick !== et) begin
      n_fail++;
      $display("FAIL %s: tick=%b expected %b at %0t", name, tick, et, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Three idle cycles holding hold_v, then the step to next_v with tick.
  task automatic one_step(input string name, input logic [3:0] hold_v, input logic [3:0] next_v);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check({name, "_hold"}, hold_v, 1'b0);
    end
    cyc();
    check({name, "_step"}, next_v, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required<100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 4'd0, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 4'd0, 1'b0};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 4'd1, 1'b1};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 4'd1, 1'b0};
    tbl[5]  = '{1'b1, 2'd0, 1'b0, 4'd1, 1'b0};
    tbl[6]  = '{1'b1, 2'd0, 1'b0, 4'd1, 1'b0};
    tbl[7]  = '{1'b1, 2'd0, 1'b0, 4'd2, 1'b1};
    tbl[8]  = '{1'b1, 2'd0, 1'b1, 4'd2, 1'b0};
    tbl[9]  = '{1'b1, 2'd0, 1'b0, 4'd2, 1'b0};
    tbl[10] = '{1'b1, 2'd0, 1'b0, 4'd2, 1'b0};
    tbl[11] = '{1'b1, 2'd0, 1'b0, 4'd3, 1'b1};
    tbl[12] = '{1'b0, 2'd0, 1'b0, 4'd3, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 1'b1, 4'd4, 1'b1};
    tbl[14] = '{1'b0, 2'd0, 1'b0, 4'd4, 1'b0};
    tbl[15] = '{1'b0, 2'd0, 1'b1, 4'd5, 1'b1};
    tbl[16] = '{1'b0, 2'd0, 1'b1, 4'd6, 1'b1};
    tbl[17] = '{1'b0, 2'd0, 1'b0, 4'd6, 1'b0};
    tbl[18] = '{1'b1, 2'd0, 1'b0, 4'd6, 1'b0};
    tbl[19] = '{1'b1, 2'd0, 1'b0, 4'd6, 1'b0};
    tbl[20] = '{1'b1, 2'd0, 1'b0, 4'd6, 1'b0};
    tbl[21] = '{1'b1, 2'd0, 1'b0, 4'd7, 1'b1};
    bseq[0] = 4'b0010; bseq[1] = 4'b0100; bseq[2] = 4'b1000; bseq[3] = 4'b0100;
    bseq[4] = 4'b0010; bseq[5] = 4'b0001; bseq[6] = 4'b0010;

    // Reset state, then release between edges.
    #2;
    check("reset", 4'd0, 1'b0);
    cyc();
    rst = 1'b0;

    // Up count, pause, manual steps, ignored step_now while running.
    for (int i = 0; i < 22; i++) begin
      en = tbl[i].en;
      mode = tbl[i].mode;
      step_now = tbl[i].step;
      cyc();
      check($sformatf("vec%0d", i), tbl[i].leds, tbl[i].tick);
    end
    en = 1'b1;
    step_now = 1'b0;

    // Up count through the 1111 -> 0000 wrap.
    exp_l = 4'd7;
    for (int s = 0; s < 10; s++) begin
      one_step("up", exp_l, exp_l + 4'd1);
      exp_l = exp_l + 4'd1;
    end
    check("up_wrap_end", 4'd1, 1'b1);

    // Mode change mid-count: seed loaded, count restarts.
    cyc(); check("pre_down", 4'd1, 1'b0);
    cyc(); check("pre_down", 4'd1, 1'b0);
    mode = 2'b01;
    cyc();
    check("down_seed", 4'b1111, 1'b0);
    one_step("down_first", 4'b1111, 4'b1110);
    exp_l = 4'b1110;
    for (int s = 0; s < 15; s++) begin
      one_step("down", exp_l, exp_l - 4'd1);
      exp_l = exp_l - 4'd1;
    end
    check("down_wrap_end", 4'b1111, 1'b1);

    // Mode change coincident with cnt==DIV-1 wins over the step.
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("pre_rot", 4'b1111, 1'b0);
    end
    mode = 2'b10;
    cyc();
    check("rot_seed_prio", 4'b0001, 1'b0);
    one_step("rot", 4'b0001, 4'b0010);
    one_step("rot", 4'b0010, 4'b0100);
    one_step("rot", 4'b0100, 4'b1000);

    // Manual step while paused rotates 1000 -> 0001.
    en = 1'b0;
    step_now = 1'b1;
    cyc();
    check("manual_rot", 4'b0001, 1'b1);
    step_now = 1'b0;
    cyc();
    check("manual_rot_after", 4'b0001, 1'b0);
    en = 1'b1;
    one_step("rot_resume", 4'b0001, 4'b0010);

    // Bounce without repeated ends.
    mode = 2'b11;
    cyc();
    check("bounce_seed", 4'b0001, 1'b0);
    exp_l = 4'b0001;
    for (int s = 0; s < 7; s++) begin
      one_step($sformatf("bounce%0d", s), exp_l, bseq[s]);
      exp_l = bseq[s];
    end

    // Async reset right after a tick edge drops the tick before the next edge.
    rst = 1'b1;
    #2;
    check("async_rst", 4'd0, 1'b0);
    cyc();
    check("rst_held", 4'd0, 1'b0);
    rst = 1'b0;
    cyc();
    check("rst_rel_seed", 4'b0001, 1'b0);
    one_step("rst_rel_bounce", 4'b0001, 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
